gray_step_monitor: RTL and testbench
====================================

// Module: gray_step_monitor
// PURPOSE
//   Downstream consumer of the N-bit gray counter output.
//   Samples the gray code and decodes it to binary.
//   Checks that consecutive samples differ by at most one bit, as the gray code guarantees.
//   Reports violations as a per-sample pulse, a sticky fault flag and a saturating error count.
// PARAMETERS
//   N   4  width of gray_in / bin_out
//   CW  8  width of err_cnt (saturates at 2**CW-1)
// PORTS
//   clk        in   1   clock, all logic on posedge
//   rstn       in   1   reset, synchronous, active-low
//   gray_in    in   N   gray-coded value from upstream counter
//   sample_en  in   1   capture gray_in this cycle
//   clr        in   1   sync clear of fault/err_cnt/history
//   bin_out    out  N   binary decode of last captured sample
//   bin_valid  out  1   1-cycle pulse: bin_out updated
//   step_err   out  1   1-cycle pulse, aligned with bin_valid: sample illegal
//   fault      out  1   sticky: any step_err since reset/clr
//   err_cnt    out  CW  saturating count of step_err pulses
//   dir_down   out  1   1-cycle pulse, aligned with bin_valid: backward step (STEP_DIR_EN only)
// BEHAVIOUR
//   Reset (rstn=0 at posedge): all outputs 0, history empty, state EMPTY.
//   Pipeline, sample_en=1 with gray_in=G at edge T:
//     T+1: g_q<=G, g_prev<=old g_q, s_v<=1.
//     T+2: bin_out<=g2b(G), bin_valid=1, step_err/dir_down evaluated.
//     Latency 2 cycles; full throughput, one sample per cycle.
//   g2b: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i], i=N-2..0.
//   dist = popcount(g_q ^ g_prev):
//     0 = hold, legal.
//     1 = step, legal.
//     >=2 = illegal -> step_err.
//   FSM (advances on the s_v stage):
//     EMPTY: first sample decoded, no compare, step_err=0 -> TRACK.
//     TRACK: compare each sample; illegal -> step_err=1, fault<=1, go FAULT.
//     FAULT: keeps decoding and comparing; further illegal samples pulse step_err and count.
//       Only clr or reset exits FAULT.
//   err_cnt increments on each step_err; holds at 2**CW-1, never wraps.
//   Wrap-around legal: gray 1000->0000 (N=4, bin 15->0) is dist 1.
//   clr=1: next edge -> state EMPTY, fault=0, err_cnt=0, in-flight s_v dropped.
//     bin_out retains its value; a sample_en in the same cycle is discarded (clr wins).
//   rstn low mid-pipeline: in-flight samples discarded, no bin_valid after release
//     until a new sample_en.
//   Non-pulse outputs are registered and hold between samples.
// CONFIGURATION
//   STEP_DIR_EN defined:
//     For dist=1, compare g2b(g_q) with g2b(g_prev).
//     g2b(g_prev)-1 mod 2**N -> dir_down=1, treated as illegal: step_err, fault, err_cnt as above.
//     The +1 step is legal.
//     Holds are unaffected.
//   STEP_DIR_EN undefined:
//     dir_down tied 0.
//     No direction check; any dist<=1 is legal.
// TESTING (N=4, CW=2)
//   1 rst, then gray 0000,0001,0011,0010 each with sample_en -> bin_out 0,1,2,3 from 2 cycles later;
//     bin_valid each cycle; step_err=0; err_cnt=0.
//   2 gray 0010 then 0111 (dist 2) -> step_err pulse with bin_out=5, fault=1, err_cnt=1.
//     Next legal 0101 -> step_err=0, fault stays 1.
//   3 gray 0010,0010,0010 and gray 1000->0000 -> no step_err (hold, wrap legal).
//   4 five illegal jumps (0000<->0011<->... alternating dist 2) -> err_cnt=3 (saturated), fault=1.
//     clr -> err_cnt=0, fault=0.
//     The next sample raises no error regardless of value (state EMPTY).
//   5 rstn=0 for 1 cycle right after a sample_en -> no bin_valid emitted, all outputs 0.
//     clr and sample_en together -> sample discarded.
//   6 STEP_DIR_EN: gray 0011->0001 (bin 2->1) -> dir_down=1, step_err=1, err_cnt=1.
//     Without macro -> dir_down=0, step_err=0.

Source files
------------

// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: decodes sampled gray values and flags multi-bit steps.
// Optional STEP_DIR_EN: additionally treats a backward (-1) step as illegal.
module gray_step_monitor #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  gray_in,
    input  logic          sample_en,
    input  logic          clr,
    output logic [N-1:0]  bin_out,
    output logic          bin_valid,
    output logic          step_err,
    output logic          fault,
    output logic [CW-1:0] err_cnt,
    output logic          dir_down
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   g_q;
    logic [N-1:0]   g_prev;
    logic           s_v;
    logic [N-1:0]   b_cur;
    logic           multi;
    logic           down;
    logic           illegal;
    logic           dir_hit;

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcnt(input logic [N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

`ifdef STEP_DIR_EN
    logic [N-1:0] b_prev;
    logic         one;
`endif

    always_comb begin
        b_cur   = g2b(g_q);
        multi   = popcnt(g_q ^ g_prev) >= 2;
`ifdef STEP_DIR_EN
        b_prev  = g2b(g_prev);
        one     = popcnt(g_q ^ g_prev) == 1;
        down    = one && (b_cur == b_prev - N'(1));
`else
        down    = 1'b0;
`endif
        // No history to compare against until the first sample lands.
        illegal = (state_q != EMPTY) && (multi || down);
        dir_hit = (state_q != EMPTY) && down;
    end

    always_comb begin
        state_d = state_q;
        if (s_v) begin
            unique case (state_q)
                EMPTY:   state_d = TRACK;
                TRACK:   state_d = illegal ? FAULT : TRACK;
                FAULT:   state_d = FAULT;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            g_q       <= '0;
            g_prev    <= '0;
            s_v       <= 1'b0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            dir_down  <= 1'b0;
            fault     <= 1'b0;
            err_cnt   <= '0;
        end else if (clr) begin
            // bin_out intentionally keeps the last decoded value.
            g_q       <= '0;
            g_prev    <= '0;
            s_v       <= 1'b0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            dir_down  <= 1'b0;
            fault     <= 1'b0;
            err_cnt   <= '0;
        end else begin
            s_v       <= sample_en;
            if (sample_en) begin
                g_q    <= gray_in;
                g_prev <= g_q;
            end
            bin_valid <= s_v;
            step_err  <= s_v && illegal;
            dir_down  <= s_v && dir_hit;
            if (s_v) begin
                bin_out <= b_cur;
            end
            if (s_v && illegal) begin
                fault <= 1'b1;
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Scoreboard bench for gray_step_monitor (N=4, CW=2) with directed gray vectors.
// Works with or without STEP_DIR_EN defined.
module tb_gray_step_monitor;

    localparam int N  = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [N-1:0]  bin;
        logic          err;
        logic          dir;
        logic          flt;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rstn;
    logic [N-1:0]  gray_in;
    logic          sample_en;
    logic          clr;
    logic [N-1:0]  bin_out;
    logic          bin_valid;
    logic          step_err;
    logic          fault;
    logic [CW-1:0] err_cnt;
    logic          dir_down;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;

`ifdef STEP_DIR_EN
    localparam logic DIRCHK = 1'b1;
`else
    localparam logic DIRCHK = 1'b0;
`endif

    gray_step_monitor #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .gray_in   (gray_in),
        .sample_en (sample_en),
        .clr       (clr),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_err  (step_err),
        .fault     (fault),
        .err_cnt   (err_cnt),
        .dir_down  (dir_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per bin_valid pulse.
    always @(negedge clk) begin
        if (rstn && !done) begin
            if (bin_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got bin %0d expected none",
                             bin_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("bin_out", int'(bin_out), int'(e.bin));
                    chk("step_err", int'(step_err), int'(e.err));
                    chk("dir_down", int'(dir_down), int'(e.dir));
                    chk("fault", int'(fault), int'(e.flt));
                    chk("err_cnt", int'(err_cnt), int'(e.cnt));
                end
            end else if (step_err || dir_down) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse: got err %0d dir %0d expected 0 0",
                         step_err, dir_down);
            end
        end
    end

    task automatic send(input logic [N-1:0] g, input int b, input int e,
                        input int d, input int f, input int c);
        exp_t x;
        @(negedge clk);
        gray_in   = g;
        sample_en = 1'b1;
        x.bin = N'(b);
        x.err = e[0];
        x.dir = d[0];
        x.flt = f[0];
        x.cnt = CW'(c);
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_en = 1'b0;
            clr       = 1'b0;
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        sample_en = 1'b0;
        clr       = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        chk("clr_fault", int'(fault), 0);
        chk("clr_cnt", int'(err_cnt), 0);
        chk("clr_valid", int'(bin_valid), 0);
    endtask

    initial begin
        rstn      = 1'b0;
        gray_in   = '0;
        sample_en = 1'b0;
        clr       = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("rst_bin", int'(bin_out), 0);
        chk("rst_valid", int'(bin_valid), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_cnt", int'(err_cnt), 0);

        // count up 0..3
        send(4'b0000, 0, 0, 0, 0, 0);
        send(4'b0001, 1, 0, 0, 0, 0);
        send(4'b0011, 2, 0, 0, 0, 0);
        send(4'b0010, 3, 0, 0, 0, 0);
        // two-bit jump, then a legal step
        send(4'b0111, 5, 1, 0, 1, 1);
        send(4'b0101, 6, 0, 0, 1, 1);
        idle(3);

        // holds and wrap-around
        do_clr();
        send(4'b0010, 3, 0, 0, 0, 0);
        send(4'b0010, 3, 0, 0, 0, 0);
        send(4'b0010, 3, 0, 0, 0, 0);
        idle(3);
        do_clr();
        send(4'b1000, 15, 0, 0, 0, 0);
        send(4'b0000, 0, 0, 0, 0, 0);
        // five illegal jumps, counter saturates at 3
        send(4'b0011, 2, 1, 0, 1, 1);
        send(4'b0000, 0, 1, 0, 1, 2);
        send(4'b0011, 2, 1, 0, 1, 3);
        send(4'b0000, 0, 1, 0, 1, 3);
        send(4'b0011, 2, 1, 0, 1, 3);
        idle(3);
        chk("sat_cnt", int'(err_cnt), 3);
        do_clr();
        chk("clr_keeps_bin", int'(bin_out), 2);
        send(4'b1111, 10, 0, 0, 0, 0);
        idle(3);

        // reset right behind a sample: it must vanish
        @(negedge clk);
        gray_in   = 4'b0110;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        rstn      = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst2_bin", int'(bin_out), 0);
        chk("rst2_valid", int'(bin_valid), 0);
        chk("rst2_err", int'(step_err), 0);
        chk("rst2_fault", int'(fault), 0);
        idle(3);

        // clr beats a simultaneous sample
        @(negedge clk);
        gray_in   = 4'b1100;
        sample_en = 1'b1;
        clr       = 1'b1;
        idle(4);

        // direction check: 2 -> 1 is a backward step
        send(4'b0001, 1, 0, 0, 0, 0);
        send(4'b0011, 2, 0, 0, 0, 0);
        send(4'b0001, 1, int'(DIRCHK), int'(DIRCHK), int'(DIRCHK), int'(DIRCHK));
        idle(4);

        chk("queue_empty", q.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
